ram_dp_param: RTL and testbench

- Parametrised simple-dual-port synchronous RAM: one write port and one read port on a single clock.
- Successor to the fixed 8x8 single-address RAM. Generalised in width and depth, with selectable read latency, a selectable read-during-write policy and a valid flag on read data.
- A built-in clear sequencer zeroes the array after every reset.
- Used as the generic storage primitive for register files, line buffers and lookup tables in the lab designs.

---
 rtl/ram_dp_param.sv | 188 ++++++++++++++++++
 tb/tb_ram_dp_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// ram_dp_param: parametrised simple-dual-port synchronous RAM with a post-reset
// clear sequencer, selectable read latency (RD_LAT 1/2) and read-during-write
// policy (RDW_MODE 0 = old data, 1 = new data).
// Ports: clk, clrn (async active-low reset), we/waddr/din (write port),
//   re/raddr (read port), dout/dout_vld (registered read data + valid pulse),
//   dout_comb (combinational mem[raddr]), init_busy (clear sequencer running).
// Optional macro RAM_PARITY_EN adds per-word even parity, input perr_inj
//   (inverts stored parity on a user write) and output rd_perr (aligned with
//   dout_vld).
module ram_dp_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
`ifdef RAM_PARITY_EN
    input  logic              perr_inj,
    output logic              rd_perr,
`endif
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    output logic [DATA_W-1:0] dout_comb,
    output logic              init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [MEM_W-1:0]  mem_q [DEPTH];

    logic              run;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  new_word;
    logic [MEM_W-1:0]  rd_word;
    logic              rd_acc;
    // Word carried down the read pipeline: data plus (optionally) error bit.
    logic [MEM_W-1:0]  src_word;
    logic              src_vld;

    logic [DATA_W-1:0] dout_q;
    logic              vld_q;

    // Sequencer -------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign run       = (state_q == S_RUN);
    assign init_busy = ~run;

    // Write port ------------------------------------------------------------
`ifdef RAM_PARITY_EN
    assign new_word = {(^din) ^ perr_inj, din};
`else
    assign new_word = din;
`endif

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = waddr;
        wr_word = new_word;
        if (!run) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_word = '0;
        end else if (we) begin
            wr_en   = 1'b1;
        end
    end

    // Array has no reset; clrn only blocks writes while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en && clrn) begin
            mem_q[wr_addr] <= wr_word;
        end
    end

    // Read port -------------------------------------------------------------
    assign rd_acc    = run & re;
    assign dout_comb = mem_q[raddr][DATA_W-1:0];

    always_comb begin
        rd_word = mem_q[raddr];
        if ((RDW_MODE == 1) && we && (waddr == raddr)) begin
            rd_word = new_word;
        end
    end

`ifdef RAM_PARITY_EN
    // Even parity: a healthy word XORs to zero across data and parity bit.
    logic [MEM_W-1:0] rd_tagged;
    assign rd_tagged = {^rd_word, rd_word[DATA_W-1:0]};
`else
    logic [MEM_W-1:0] rd_tagged;
    assign rd_tagged = rd_word;
`endif

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [MEM_W-1:0] s1_word_q;
            logic             s1_vld_q;

            always_ff @(posedge clk or negedge clrn) begin
                if (!clrn) begin
                    s1_word_q <= '0;
                    s1_vld_q  <= 1'b0;
                end else begin
                    s1_vld_q <= rd_acc;
                    if (rd_acc) begin
                        s1_word_q <= rd_tagged;
                    end
                end
            end

            assign src_word = s1_word_q;
            assign src_vld  = s1_vld_q;
        end else begin : g_lat1
            assign src_word = rd_tagged;
            assign src_vld  = rd_acc;
        end
    endgenerate

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= src_vld;
            if (src_vld) begin
                dout_q <= src_word[DATA_W-1:0];
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= src_vld & src_word[DATA_W];
        end
    end
    assign rd_perr = perr_q;
`endif

    assign dout     = dout_q;
    assign dout_vld = vld_q;

endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param: self-checking bench for ram_dp_param, two instances
// (RD_LAT=1/RDW_MODE=0 and RD_LAT=2/RDW_MODE=1) against a behavioural model.
module tb_ram_dp_param;

    logic       clk = 1'b0;
    logic       clrn;
    logic       we, re;
    logic [2:0] waddr, raddr;
    logic [7:0] din;

    logic [7:0] d0, c0, d1, c1;
    logic       v0, b0, v1, b1;
`ifdef RAM_PARITY_EN
    logic       perr_inj;
    logic       pe0, pe1;
`endif

    always #5 clk = ~clk;

    ram_dp_param #(.DATA_W(8), .ADDR_W(3), .RD_LAT(1), .RDW_MODE(0)) u0 (
        .clk(clk), .clrn(clrn), .we(we), .waddr(waddr), .din(din),
        .re(re), .raddr(raddr),
`ifdef RAM_PARITY_EN
        .perr_inj(perr_inj), .rd_perr(pe0),
`endif
        .dout(d0), .dout_vld(v0), .dout_comb(c0), .init_busy(b0)
    );

    ram_dp_param #(.DATA_W(8), .ADDR_W(3), .RD_LAT(2), .RDW_MODE(1)) u1 (
        .clk(clk), .clrn(clrn), .we(we), .waddr(waddr), .din(din),
        .re(re), .raddr(raddr),
`ifdef RAM_PARITY_EN
        .perr_inj(perr_inj), .rd_perr(pe1),
`endif
        .dout(d1), .dout_vld(v1), .dout_comb(c1), .init_busy(b1)
    );

    // Behavioural reference
    logic [7:0] m_mem [8];
    bit         m_known [8];
    int         clr_left, clr_idx;
    logic [7:0] e_d0, e_d1, p_d1;
    bit         e_v0, e_v1, p_v1;

    int errs = 0;
    int checks = 0;

    typedef struct {
        bit         w;
        logic [2:0] wa;
        logic [7:0] d;
        bit         r;
        logic [2:0] ra;
        logic [7:0] xd0;
        bit         xv0;
        logic [7:0] xd1;
        bit         xv1;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit w, input logic [2:0] wa,
                              input logic [7:0] d, input bit r,
                              input logic [2:0] ra);
        logic [7:0] old, nw;
        e_v1 = p_v1;
        if (p_v1) e_d1 = p_d1;
        if (clr_left > 0) begin
            m_mem[clr_idx]   = 8'h00;
            m_known[clr_idx] = 1'b1;
            clr_idx++;
            clr_left--;
            e_v0 = 1'b0;
            p_v1 = 1'b0;
        end else begin
            old  = m_mem[ra];
            nw   = (w && wa == ra) ? d : old;
            e_v0 = r;
            if (r) e_d0 = old;
            p_v1 = r;
            p_d1 = nw;
            if (w) begin
                m_mem[wa]   = d;
                m_known[wa] = 1'b1;
            end
        end
    endtask

    task automatic cyc(input bit w, input logic [2:0] wa, input logic [7:0] d,
                       input bit r, input logic [2:0] ra);
        we = w; waddr = wa; din = d; re = r; raddr = ra;
        @(posedge clk);
        model_edge(w, wa, d, r, ra);
        #1;
        chk("busy0", b0, clr_left > 0);
        chk("busy1", b1, clr_left > 0);
        chk("vld0", v0, e_v0);
        chk("dout0", d0, e_d0);
        chk("vld1", v1, e_v1);
        chk("dout1", d1, e_d1);
        if (m_known[ra]) begin
            chk("comb0", c0, m_mem[ra]);
            chk("comb1", c1, m_mem[ra]);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int hold);
        clrn = 1'b0;
        #1;
        chk("rst_dout0", d0, 8'h00);
        chk("rst_vld0", v0, 1'b0);
        chk("rst_busy0", b0, 1'b1);
        chk("rst_dout1", d1, 8'h00);
        chk("rst_vld1", v1, 1'b0);
        chk("rst_busy1", b1, 1'b1);
        clr_left = 8; clr_idx = 0;
        e_d0 = 0; e_d1 = 0; e_v0 = 0; e_v1 = 0; p_v1 = 0; p_d1 = 0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        chk("rel_busy0", b0, 1'b1);
        chk("rel_busy1", b1, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1, 3, 8'hA5, 0, 3, 8'h00, 0, 8'h00, 0};
        tbl[1] = '{0, 0, 8'h00, 1, 3, 8'hA5, 1, 8'h00, 0};
        tbl[2] = '{1, 5, 8'h20, 0, 3, 8'hA5, 0, 8'hA5, 1};
        tbl[3] = '{1, 5, 8'h7E, 1, 5, 8'h20, 1, 8'hA5, 0};
        tbl[4] = '{0, 0, 8'h00, 1, 5, 8'h7E, 1, 8'h7E, 1};
        tbl[5] = '{0, 0, 8'h00, 0, 0, 8'h7E, 0, 8'h7E, 1};
        tbl[6] = '{0, 0, 8'h00, 0, 0, 8'h7E, 0, 8'h7E, 0};

        clrn = 1'b0; we = 0; re = 0; waddr = 0; raddr = 0; din = 0;
`ifdef RAM_PARITY_EN
        perr_inj = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = 8'h00;
        end
        @(negedge clk);
        do_reset(2);

        // we/re during clear must be ignored
        for (int i = 0; i < 8; i++) cyc(1, 3'(i), 8'hFF, 1, 3'(i));
        for (int i = 0; i < 8; i++) cyc(0, 0, 8'h00, 1, 3'(i));
        cyc(0, 0, 8'h00, 0, 0);

        // Directed latency and read-during-write vectors
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].w, tbl[i].wa, tbl[i].d, tbl[i].r, tbl[i].ra);
            chk($sformatf("tbl%0d_d0", i), d0, tbl[i].xd0);
            chk($sformatf("tbl%0d_v0", i), v0, tbl[i].xv0);
            chk($sformatf("tbl%0d_d1", i), d1, tbl[i].xd1);
            chk($sformatf("tbl%0d_v1", i), v1, tbl[i].xv1);
        end

        // Streaming
        for (int a = 0; a < 8; a++) cyc(1, 3'(a), 8'(8'h10 + a), 0, 0);
        for (int a = 0; a < 8; a++) begin
            cyc(0, 0, 8'h00, 1, 3'(a));
            chk($sformatf("stream%0d", a), {v0, d0}, {1'b1, 8'(8'h10 + a)});
        end
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)), 3'($urandom));
        end

        // Reset mid-clear
        do_reset(1);
        for (int i = 0; i < 4; i++) cyc(1, 3'(i), 8'h55, 1, 3'(i));
        do_reset(1);
        for (int i = 0; i < 8; i++) cyc(1, 3'(7 - i), 8'hAA, 1, 3'(i));
        for (int i = 0; i < 8; i++) cyc(0, 0, 8'h00, 1, 3'(i));
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);

`ifdef RAM_PARITY_EN
        perr_inj = 1'b1;
        cyc(1, 2, 8'h0F, 0, 0);
        perr_inj = 1'b0;
        cyc(0, 0, 8'h00, 1, 2);
        chk("perr0_inj", pe0, 1'b1);
        cyc(0, 0, 8'h00, 0, 0);
        chk("perr1_inj", pe1, 1'b1);
        cyc(1, 2, 8'h0F, 0, 0);
        cyc(0, 0, 8'h00, 1, 2);
        chk("perr0_ok", pe0, 1'b0);
        cyc(0, 0, 8'h00, 0, 0);
        chk("perr1_ok", pe1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
